// File: rtl/gfsk_tx_modulator.sv
// gfsk_tx_modulator: serial bit stream to I/Q baseband samples, MSK/GFSK with h = 0.5.
// A phase accumulator steps +/-90 degrees per symbol and indexes sin/cos tables.
// Optional macro GFSK_GAUSS_EN: box-filter frequency shaping plus a DRAIN state.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | waiting for the first bit, i/q held at 0, bit_ready high
// S_RUN   | emitting SAMPLE_RATE samples per symbol, next bit taken at boundary
// S_DRAIN | (GFSK_GAUSS_EN only) flushing the box filter with zero deviation
module gfsk_tx_modulator #(
    parameter int SAMPLE_RATE = 16,
    parameter int DATA_WIDTH  = 4,
    parameter int PHASE_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  en,
    input  logic                  bit_data,
    input  logic                  bit_valid,
    input  logic                  bit_last,
    output logic                  bit_ready,
    output logic [DATA_WIDTH-1:0] i_data,
    output logic [DATA_WIDTH-1:0] q_data,
    output logic                  symbol_strobe,
    output logic                  busy,
    output logic                  underrun_err
);

    localparam int STEP   = (2 ** (PHASE_WIDTH - 2)) / SAMPLE_RATE;
    localparam int CNT_W  = $clog2(SAMPLE_RATE);
    localparam int TAB_N  = 2 ** PHASE_WIDTH;
    localparam int TAB_W  = TAB_N * DATA_WIDTH;
    localparam int TAB_IW = $clog2(TAB_W);
`ifdef GFSK_GAUSS_EN
    localparam int L      = SAMPLE_RATE / 2;
    localparam int FRAC   = $clog2(L);
    localparam int SUM_W  = FRAC + 2;
`else
    localparam int FRAC   = 0;
`endif
    localparam int ACC_W  = PHASE_WIDTH + FRAC;

    localparam logic [ACC_W-1:0] STEP_V   = ACC_W'(STEP);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(SAMPLE_RATE - 1);
`ifdef GFSK_GAUSS_EN
    localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'(L - 1);
`endif

    // Elaboration-time table: round(A * cos/sin(2*pi*n/2^PHASE_WIDTH)), ties away from zero.
    function automatic logic [TAB_W-1:0] build_table(input logic sine);
        logic [TAB_W-1:0] t;
        real amp;
        real ang;
        real x;
        int  v;
        t   = '0;
        amp = real'((2 ** (DATA_WIDTH - 1)) - 1);
        for (int n = 0; n < TAB_N; n++) begin
            ang = 6.283185307179586 * real'(n) / real'(TAB_N);
            x   = sine ? amp * $sin(ang) : amp * $cos(ang);
            if (x >= 0.0) v = $rtoi($floor(x + 0.5));
            else          v = -$rtoi($floor(-x + 0.5));
            t[n*DATA_WIDTH +: DATA_WIDTH] = v[DATA_WIDTH-1:0];
        end
        return t;
    endfunction

    localparam logic [TAB_W-1:0] COS_TAB = build_table(1'b0);
    localparam logic [TAB_W-1:0] SIN_TAB = build_table(1'b1);

`ifdef GFSK_GAUSS_EN
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;
`else
    typedef enum logic {S_IDLE, S_RUN} state_t;
`endif

    state_t                state_q, state_d;
    logic [ACC_W-1:0]      phase_q, phase_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  cur_bit_q, cur_bit_d;
    logic                  last_seen_q, last_seen_d;
    logic [DATA_WIDTH-1:0] i_q, i_d;
    logic [DATA_WIDTH-1:0] q_q, q_d;
    logic                  strobe_q, strobe_d;
    logic                  err_q, err_d;
`ifdef GFSK_GAUSS_EN
    // Deviation history, two-bit signed entries, newest in the low bits.
    logic [2*L-1:0]        dev_sr_q, dev_sr_d;
    logic [SUM_W-1:0]      sum_q, sum_d;
    logic [2*L-1:0]        sr_base;
    logic [SUM_W-1:0]      sum_base;
`endif

    logic                   out_en;
    logic                   out_zero;
    logic [PHASE_WIDTH-1:0] out_idx;
    logic                   adv;
    logic                   adv_restart;
    logic [1:0]             adv_dev;
    logic [ACC_W-1:0]       phase_base;
    logic [TAB_IW-1:0]      tab_base;

    assign bit_ready = (state_q == S_IDLE) |
                       ((state_q == S_RUN) & (cnt_q == LAST_CNT) & ~last_seen_q);

    // Per en-cycle decode: choose the sample to emit and the deviation to accumulate.
    always_comb begin
        state_d     = state_q;
        phase_d     = phase_q;
        cnt_d       = cnt_q;
        cur_bit_d   = cur_bit_q;
        last_seen_d = last_seen_q;
        i_d         = i_q;
        q_d         = q_q;
        strobe_d    = strobe_q;
        err_d       = err_q;
        out_en      = 1'b0;
        out_zero    = 1'b0;
        out_idx     = phase_q[ACC_W-1 -: PHASE_WIDTH];
        adv         = 1'b0;
        adv_restart = 1'b0;
        adv_dev     = 2'b00;
        phase_base  = phase_q;
        tab_base    = '0;
`ifdef GFSK_GAUSS_EN
        dev_sr_d    = dev_sr_q;
        sum_d       = sum_q;
        sr_base     = dev_sr_q;
        sum_base    = sum_q;
`endif
        if (en) begin
            case (state_q)
                S_IDLE: begin
                    if (bit_valid) begin
                        state_d     = S_RUN;
                        cnt_d       = '0;
                        cur_bit_d   = bit_data;
                        last_seen_d = bit_last;
                        err_d       = 1'b0;
                        strobe_d    = 1'b1;
                        out_en      = 1'b1;
                        out_idx     = '0;
                        adv         = 1'b1;
                        adv_restart = 1'b1;
                        adv_dev     = bit_data ? 2'b01 : 2'b11;
                    end
                end
                S_RUN: begin
                    if (cnt_q != LAST_CNT) begin
                        cnt_d    = cnt_q + 1'b1;
                        strobe_d = 1'b0;
                        out_en   = 1'b1;
                        adv      = 1'b1;
                        adv_dev  = cur_bit_q ? 2'b01 : 2'b11;
                    end else if (!last_seen_q && bit_valid) begin
                        // Boundary transfer: phase carries straight on into the new symbol.
                        cnt_d       = '0;
                        cur_bit_d   = bit_data;
                        last_seen_d = bit_last;
                        strobe_d    = 1'b1;
                        out_en      = 1'b1;
                        adv         = 1'b1;
                        adv_dev     = bit_data ? 2'b01 : 2'b11;
                    end else begin
                        // Packet end, either flagged by last or forced by a missing bit.
                        err_d    = err_q | ~last_seen_q;
                        cnt_d    = '0;
                        strobe_d = 1'b0;
`ifdef GFSK_GAUSS_EN
                        state_d  = S_DRAIN;
                        out_en   = 1'b1;
                        adv      = 1'b1;
                        adv_dev  = 2'b00;
`else
                        state_d  = S_IDLE;
                        out_zero = 1'b1;
                        phase_d  = '0;
`endif
                    end
                end
`ifdef GFSK_GAUSS_EN
                S_DRAIN: begin
                    strobe_d = 1'b0;
                    if (cnt_q == DRAIN_LAST) begin
                        state_d  = S_IDLE;
                        cnt_d    = '0;
                        out_zero = 1'b1;
                        phase_d  = '0;
                    end else begin
                        cnt_d   = cnt_q + 1'b1;
                        out_en  = 1'b1;
                        adv     = 1'b1;
                        adv_dev = 2'b00;
                    end
                end
`endif
                default: state_d = S_IDLE;
            endcase
        end

        if (adv) begin
            if (adv_restart) phase_base = '0;
`ifdef GFSK_GAUSS_EN
            if (adv_restart) begin
                sr_base  = '0;
                sum_base = '0;
            end
            dev_sr_d = {sr_base[2*L-3:0], adv_dev};
            sum_d    = sum_base + {{(SUM_W-2){adv_dev[1]}}, adv_dev}
                                - {{(SUM_W-2){sr_base[2*L-1]}}, sr_base[2*L-1 -: 2]};
            // sum*STEP/L in phase units equals sum*STEP once log2(L) fraction bits are carried.
            phase_d  = phase_base + ({{(ACC_W-SUM_W){sum_d[SUM_W-1]}}, sum_d} * STEP_V);
`else
            phase_d  = phase_base + (adv_dev[1] ? -STEP_V : STEP_V);
`endif
        end

        if (out_en) begin
            tab_base = TAB_IW'(out_idx) * TAB_IW'(DATA_WIDTH);
            i_d      = COS_TAB[tab_base +: DATA_WIDTH];
            q_d      = SIN_TAB[tab_base +: DATA_WIDTH];
        end else if (out_zero) begin
            i_d = '0;
            q_d = '0;
        end
    end

    // State and output registers; en=0 leaves every _d equal to its _q.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= S_IDLE;
            phase_q     <= '0;
            cnt_q       <= '0;
            cur_bit_q   <= 1'b0;
            last_seen_q <= 1'b0;
            i_q         <= '0;
            q_q         <= '0;
            strobe_q    <= 1'b0;
            err_q       <= 1'b0;
`ifdef GFSK_GAUSS_EN
            dev_sr_q    <= '0;
            sum_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            phase_q     <= phase_d;
            cnt_q       <= cnt_d;
            cur_bit_q   <= cur_bit_d;
            last_seen_q <= last_seen_d;
            i_q         <= i_d;
            q_q         <= q_d;
            strobe_q    <= strobe_d;
            err_q       <= err_d;
`ifdef GFSK_GAUSS_EN
            dev_sr_q    <= dev_sr_d;
            sum_q       <= sum_d;
`endif
        end
    end

    assign i_data        = i_q;
    assign q_data        = q_q;
    assign symbol_strobe = strobe_q;
    assign underrun_err  = err_q;
    assign busy          = (state_q != S_IDLE);

endmodule

// File: tb/tb_gfsk_tx_modulator.sv
// Bench for gfsk_tx_modulator: expected samples are queued from a reference model
// when a packet is prepared and popped against the captured DUT samples.
module tb_gfsk_tx_modulator;

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic       en = 1'b0;
    logic       bit_data = 1'b0;
    logic       bit_valid = 1'b0;
    logic       bit_last = 1'b0;
    logic       bit_ready;
    logic [3:0] i_data;
    logic [3:0] q_data;
    logic       symbol_strobe;
    logic       busy;
    logic       underrun_err;

    gfsk_tx_modulator #(.SAMPLE_RATE(16), .DATA_WIDTH(4), .PHASE_WIDTH(8)) dut (
        .clk(clk), .resetn(resetn), .en(en),
        .bit_data(bit_data), .bit_valid(bit_valid), .bit_last(bit_last),
        .bit_ready(bit_ready), .i_data(i_data), .q_data(q_data),
        .symbol_strobe(symbol_strobe), .busy(busy), .underrun_err(underrun_err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] i;
        logic [3:0] q;
        logic       s;
    } smp_t;

    smp_t       exp_q[$];
    smp_t       obs_q[$];
    int         n_pass = 0;
    int         n_total = 0;
    int         busy_cycles;
    int         first_wait;
    bit         timed_out;
    logic [3:0] idle_i;
    logic [3:0] idle_q;
    logic       err_after_first;

    function automatic logic [3:0] ref_amp(input int p, input bit sine);
        real ang;
        real x;
        int  v;
        ang = 6.283185307179586 * real'(p) / 256.0;
        x   = sine ? 7.0 * $sin(ang) : 7.0 * $cos(ang);
        if (x >= 0.0) v = $rtoi($floor(x + 0.5));
        else          v = -$rtoi($floor(-x + 0.5));
        return v[3:0];
    endfunction

    function automatic smp_t mk(input logic [3:0] i, input logic [3:0] q, input logic s);
        smp_t r;
        r.i = i;
        r.q = q;
        r.s = s;
        return r;
    endfunction

    // Unshaped reference: phase of sample n is the sum of the steps of samples before it.
    task automatic model_packet(input logic [31:0] bits, input int nbits);
        int p;
        p = 0;
        exp_q.delete();
        for (int k = 0; k < nbits; k++) begin
            for (int s = 0; s < 16; s++) begin
                exp_q.push_back(mk(ref_amp(p, 1'b0), ref_amp(p, 1'b1), s == 0));
                p = (p + (bits[k] ? 4 : 252)) % 256;
            end
        end
    endtask

    // Drive one packet and capture every en-cycle sample produced while busy.
    task automatic drive_packet(input logic [31:0] bits, input int nbits,
                                input int en_div, input bit no_last);
        int idx;
        int cyc;
        bit started;
        bit done;
        bit xfer;
        bit en_now;
        idx = 0; cyc = 0; started = 0; done = 0;
        busy_cycles = 0; first_wait = 0; timed_out = 0;
        err_after_first = 1'bx;
        obs_q.delete();
        while (!done && cyc < 3000) begin
            @(negedge clk);
            en_now    = (cyc % en_div) == 0;
            en        = en_now;
            bit_valid = idx < nbits;
            bit_data  = (idx < nbits) ? bits[idx] : 1'b0;
            bit_last  = !no_last && (idx == nbits - 1);
            #1;
            xfer = en_now && bit_valid && bit_ready;
            @(posedge clk);
            #1;
            cyc++;
            if (xfer) begin
                if (idx == 0) err_after_first = underrun_err;
                idx++;
                started = 1;
            end
            if (en_now && busy) begin
                obs_q.push_back(mk(i_data, q_data, symbol_strobe));
                busy_cycles++;
            end
            if (en_now && !started) first_wait++;
            if (en_now && started && !busy) begin
                done   = 1;
                idle_i = i_data;
                idle_q = q_data;
            end
        end
        timed_out = !done;
        @(negedge clk);
        en = 1'b0; bit_valid = 1'b0; bit_last = 1'b0;
    endtask

    task automatic test_reset;
        #1;
        n_total++; if ({i_data, q_data} !== 8'h00) $display("FAIL reset_iq: got i=%0d q=%0d, want 0 0", i_data, q_data); else n_pass++;
        n_total++; if ({busy, symbol_strobe, underrun_err, bit_ready} !== 4'b0001)
            $display("FAIL reset_flags: got busy/strobe/err/ready=%b, want 0001", {busy, symbol_strobe, underrun_err, bit_ready}); else n_pass++;
        @(negedge clk); resetn = 1'b1;
        @(negedge clk); en = 1'b1; bit_valid = 1'b1; bit_data = 1'b1; bit_last = 1'b0;
        repeat (6) @(posedge clk);
        @(negedge clk); #2 resetn = 1'b0; #1;
        n_total++; if ({i_data, q_data} !== 8'h00) $display("FAIL midrun_reset_iq: got i=%0d q=%0d, want 0 0", i_data, q_data); else n_pass++;
        n_total++; if ({busy, symbol_strobe, bit_ready} !== 3'b001)
            $display("FAIL midrun_reset_flags: got busy/strobe/ready=%b, want 001", {busy, symbol_strobe, bit_ready}); else n_pass++;
        @(negedge clk); resetn = 1'b1; bit_valid = 1'b0;
        @(posedge clk); #1;
        n_total++; if ({busy, bit_ready, i_data, q_data} !== 10'b01_0000_0000)
            $display("FAIL post_reset_idle: got busy=%b ready=%b i=%0d q=%0d, want 1 ready idle zeros", busy, bit_ready, i_data, q_data); else n_pass++;
        @(negedge clk); en = 1'b0;
    endtask

    task automatic test_four_ones;
        smp_t e;
        smp_t o;
        int   k;
        model_packet(32'b1111, 4);
        drive_packet(32'b1111, 4, 1, 1'b0);
        n_total++; if (timed_out) $display("FAIL four_ones_timeout: packet did not finish"); else n_pass++;
        n_total++; if (obs_q.size() != 64) $display("FAIL four_ones_count: got %0d samples, want 64", obs_q.size()); else n_pass++;
        o = (obs_q.size() > 32) ? obs_q[32] : 'x;
        n_total++; if (o !== mk(4'h9, 4'h0, 1'b1)) $display("FAIL four_ones_s32: got i=%0d q=%0d s=%b, want -7 0 1", $signed(o.i), $signed(o.q), o.s); else n_pass++;
        o = (obs_q.size() > 48) ? obs_q[48] : 'x;
        n_total++; if (o !== mk(4'h0, 4'h9, 1'b1)) $display("FAIL four_ones_s48: got i=%0d q=%0d s=%b, want 0 -7 1", $signed(o.i), $signed(o.q), o.s); else n_pass++;
        n_total++; if ({idle_i, idle_q, busy} !== 9'h000) $display("FAIL four_ones_idle: got i=%0d q=%0d busy=%b, want 0 0 0", idle_i, idle_q, busy); else n_pass++;
        k = 0;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = (obs_q.size() > 0) ? obs_q.pop_front() : 'x;
            n_total++;
            if (o !== e) $display("FAIL four_ones_sample %0d: got i=%0d q=%0d s=%b, want i=%0d q=%0d s=%b",
                                  k, $signed(o.i), $signed(o.q), o.s, $signed(e.i), $signed(e.q), e.s);
            else n_pass++;
            k++;
        end
    endtask

    task automatic test_one_zero;
        smp_t e;
        smp_t o;
        int   k;
        model_packet(32'b01, 2);
        drive_packet(32'b01, 2, 1, 1'b0);
        n_total++; if (timed_out || obs_q.size() != 32) $display("FAIL one_zero_count: got %0d samples (timeout=%b), want 32", obs_q.size(), timed_out); else n_pass++;
        o = (obs_q.size() > 16) ? obs_q[16] : 'x;
        n_total++; if (o !== mk(4'h0, 4'h7, 1'b1)) $display("FAIL one_zero_s16: got i=%0d q=%0d s=%b, want 0 7 1", $signed(o.i), $signed(o.q), o.s); else n_pass++;
        o = (obs_q.size() > 31) ? obs_q[31] : 'x;
        n_total++; if (o !== mk(4'h7, 4'h1, 1'b0)) $display("FAIL one_zero_s31: got i=%0d q=%0d s=%b, want 7 1 0", $signed(o.i), $signed(o.q), o.s); else n_pass++;
        k = 0;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = (obs_q.size() > 0) ? obs_q.pop_front() : 'x;
            n_total++;
            if (o !== e) $display("FAIL one_zero_sample %0d: got i=%0d q=%0d s=%b, want i=%0d q=%0d s=%b",
                                  k, $signed(o.i), $signed(o.q), o.s, $signed(e.i), $signed(e.q), e.s);
            else n_pass++;
            k++;
        end
    endtask

    task automatic test_underrun;
        smp_t e;
        smp_t o;
        int   k;
        model_packet(32'b1, 1);
        drive_packet(32'b1, 1, 1, 1'b1);
        n_total++; if (timed_out || obs_q.size() != 16) $display("FAIL underrun_count: got %0d samples (timeout=%b), want 16", obs_q.size(), timed_out); else n_pass++;
        n_total++; if (underrun_err !== 1'b1) $display("FAIL underrun_flag: got %b, want 1", underrun_err); else n_pass++;
        n_total++; if ({idle_i, idle_q, busy} !== 9'h000) $display("FAIL underrun_idle: got i=%0d q=%0d busy=%b, want 0 0 0", idle_i, idle_q, busy); else n_pass++;
        k = 0;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = (obs_q.size() > 0) ? obs_q.pop_front() : 'x;
            n_total++;
            if (o !== e) $display("FAIL underrun_sample %0d: got i=%0d q=%0d s=%b, want i=%0d q=%0d s=%b",
                                  k, $signed(o.i), $signed(o.q), o.s, $signed(e.i), $signed(e.q), e.s);
            else n_pass++;
            k++;
        end
        model_packet(32'b0, 1);
        drive_packet(32'b0, 1, 1, 1'b0);
        n_total++; if (err_after_first !== 1'b0) $display("FAIL underrun_clear: got %b after next accept, want 0", err_after_first); else n_pass++;
        n_total++; if (obs_q.size() != 16) $display("FAIL single_bit_count: got %0d samples, want 16", obs_q.size()); else n_pass++;
    endtask

    task automatic test_en_toggle;
        smp_t e;
        smp_t o;
        int   k;
        model_packet(32'b11, 2);
        drive_packet(32'b11, 2, 3, 1'b0);
        n_total++; if (timed_out || obs_q.size() != 32) $display("FAIL en_toggle_count: got %0d samples (timeout=%b), want 32", obs_q.size(), timed_out); else n_pass++;
        k = 0;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = (obs_q.size() > 0) ? obs_q.pop_front() : 'x;
            n_total++;
            if (o !== e) $display("FAIL en_toggle_sample %0d: got i=%0d q=%0d s=%b, want i=%0d q=%0d s=%b",
                                  k, $signed(o.i), $signed(o.q), o.s, $signed(e.i), $signed(e.q), e.s);
            else n_pass++;
            k++;
        end
    endtask

    task automatic test_back_to_back;
        smp_t e;
        smp_t o;
        int   k;
        model_packet(32'b0, 1);
        drive_packet(32'b0, 1, 1, 1'b0);
        n_total++; if ({idle_i, idle_q} !== 8'h00) $display("FAIL b2b_gap_iq: got i=%0d q=%0d, want 0 0", idle_i, idle_q); else n_pass++;
        model_packet(32'b10, 2);
        drive_packet(32'b10, 2, 1, 1'b0);
        n_total++; if (first_wait != 0) $display("FAIL b2b_first_wait: got %0d extra idle cycles, want 0", first_wait); else n_pass++;
        k = 0;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = (obs_q.size() > 0) ? obs_q.pop_front() : 'x;
            n_total++;
            if (o !== e) $display("FAIL b2b_sample %0d: got i=%0d q=%0d s=%b, want i=%0d q=%0d s=%b",
                                  k, $signed(o.i), $signed(o.q), o.s, $signed(e.i), $signed(e.q), e.s);
            else n_pass++;
            k++;
        end
    endtask

`ifdef GFSK_GAUSS_EN
    task automatic test_gauss;
        smp_t o;
        drive_packet(32'hFF, 8, 1, 1'b0);
        n_total++; if (timed_out || busy_cycles != 136) $display("FAIL gauss_busy: got %0d busy cycles (timeout=%b), want 136", busy_cycles, timed_out); else n_pass++;
        o = (obs_q.size() > 0) ? obs_q[0] : 'x;
        n_total++; if (o !== mk(4'h7, 4'h0, 1'b1)) $display("FAIL gauss_s0: got i=%0d q=%0d s=%b, want 7 0 1", $signed(o.i), $signed(o.q), o.s); else n_pass++;
        o = (obs_q.size() > 0) ? obs_q[obs_q.size()-1] : 'x;
        n_total++; if (o !== mk(4'h7, 4'h0, 1'b0)) $display("FAIL gauss_drain_end: got i=%0d q=%0d s=%b, want 7 0 0", $signed(o.i), $signed(o.q), o.s); else n_pass++;
        n_total++; if ({idle_i, idle_q, busy, bit_ready} !== 10'b0000_0000_01) $display("FAIL gauss_idle: got i=%0d q=%0d busy=%b ready=%b", idle_i, idle_q, busy, bit_ready); else n_pass++;
    endtask
`endif

    initial begin
        test_reset();
`ifdef GFSK_GAUSS_EN
        test_gauss();
`else
        test_four_ones();
        test_one_zero();
        test_underrun();
        test_en_toggle();
        test_back_to_back();
`endif
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
